// File: rtl/ov7670_line_buffer_if.sv
// Capture-side byte stream and pixel-side valid/ready stream of the OV7670
// line buffer, bundled so the buffer and its neighbours share one port.
interface ov7670_line_buffer_if;
    logic [7:0]  din;
    logic        hsync;
    logic        vde;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;
    logic        line_drop;
    logic        short_line;

    modport master (
        output din,
        output hsync,
        output vde,
        output pix_ready,
        input  pix_data,
        input  pix_valid,
        input  pix_last,
        input  line_drop,
        input  short_line
    );

    modport slave (
        input  din,
        input  hsync,
        input  vde,
        input  pix_ready,
        output pix_data,
        output pix_valid,
        output pix_last,
        output line_drop,
        output short_line
    );
endinterface

// File: rtl/ov7670_line_buffer.sv
// Ping-pong line buffer: packs OV7670 capture bytes into RGB565 pixels, stores
// whole lines in two RAM banks and replays completed lines over valid/ready.
module ov7670_line_buffer #(
    parameter int LINE_PIXELS = 640,
    parameter int ADDR_WIDTH  = 10
) (
    input logic                clk,
    input logic                reset,
    ov7670_line_buffer_if.slave bus
);

    localparam int RAM_AW    = ADDR_WIDTH + 1;
    localparam int RAM_DEPTH = 2 * LINE_PIXELS;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(LINE_PIXELS - 1);
    localparam logic [RAM_AW-1:0]     BANK1_BASE = RAM_AW'(LINE_PIXELS);

    logic [15:0] mem [RAM_DEPTH];

    logic                  wrEn_q;
    logic                  bytePhase_q;
    logic                  wrBank_q;
    logic [ADDR_WIDTH-1:0] wrAddr_q;
    logic [7:0]            hiByte_q;
    logic                  lineDrop_q;
    logic                  shortLine_q;

    logic [1:0]            bankFull_q;
    logic [1:0]            bankFull_d;

    logic                  rdBank_q;
    logic [ADDR_WIDTH-1:0] rdAddr_q;
    logic                  rdDone_q;

    logic [15:0]           preData_q;
    logic                  preValid_q;
    logic                  preLast_q;
    logic [15:0]           outData_q;
    logic                  outValid_q;
    logic                  outLast_q;

    logic                  pixWrite;
    logic                  commit;
    logic                  outAccept;
    logic                  lineFree;
    logic                  outLoad;
    logic                  rdIssue;
    logic [1:0]            occupancy;
    logic [RAM_AW-1:0]     wrPtr;
    logic [RAM_AW-1:0]     rdPtr;

    // Two pipeline slots (prefetch + output) hold at most two pixels, so a
    // read is only issued when the slot it lands in is guaranteed free.
    always_comb begin
        pixWrite  = !bus.hsync && bus.vde && wrEn_q && bytePhase_q;
        commit    = pixWrite && (wrAddr_q == LAST_ADDR);
        outAccept = outValid_q && bus.pix_ready;
        lineFree  = outAccept && outLast_q;
        outLoad   = preValid_q && (!outValid_q || bus.pix_ready);
        occupancy = {1'b0, outValid_q} + {1'b0, preValid_q} - {1'b0, outAccept};
        rdIssue   = bankFull_q[rdBank_q] && !rdDone_q && (occupancy < 2'd2);
        wrPtr     = wrBank_q ? (BANK1_BASE + {1'b0, wrAddr_q}) : {1'b0, wrAddr_q};
        rdPtr     = rdBank_q ? (BANK1_BASE + {1'b0, rdAddr_q}) : {1'b0, rdAddr_q};
    end

    always_comb begin
        bankFull_d = bankFull_q;
        if (commit) begin
            bankFull_d[wrBank_q] = 1'b1;
        end
        if (lineFree) begin
            bankFull_d[rdBank_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bankFull_q <= 2'b00;
        end else begin
            bankFull_q <= bankFull_d;
        end
    end

    // The hsync test uses the registered bank flags, so a free landing on
    // the same edge is not yet visible and the new line is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrEn_q      <= 1'b0;
            bytePhase_q <= 1'b0;
            wrBank_q    <= 1'b0;
            wrAddr_q    <= '0;
            hiByte_q    <= '0;
            lineDrop_q  <= 1'b0;
            shortLine_q <= 1'b0;
        end else begin
            lineDrop_q  <= 1'b0;
            shortLine_q <= 1'b0;
            if (bus.hsync) begin
                bytePhase_q <= 1'b0;
                wrAddr_q    <= '0;
                shortLine_q <= wrEn_q;
                lineDrop_q  <= bankFull_q[wrBank_q];
                wrEn_q      <= ~bankFull_q[wrBank_q];
            end else if (bus.vde && wrEn_q) begin
                bytePhase_q <= ~bytePhase_q;
                if (!bytePhase_q) begin
                    hiByte_q <= bus.din;
                end else if (commit) begin
                    wrBank_q <= ~wrBank_q;
                    wrEn_q   <= 1'b0;
                end else begin
                    wrAddr_q <= wrAddr_q + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // The read pointer runs ahead of acceptance; the bank is only released
    // once the pixel carrying pix_last has actually been taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdBank_q <= 1'b0;
            rdAddr_q <= '0;
            rdDone_q <= 1'b0;
        end else if (lineFree) begin
            rdBank_q <= ~rdBank_q;
            rdAddr_q <= '0;
            rdDone_q <= 1'b0;
        end else if (rdIssue) begin
            if (rdAddr_q == LAST_ADDR) begin
                rdDone_q <= 1'b1;
            end else begin
                rdAddr_q <= rdAddr_q + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pixWrite) begin
            mem[wrPtr] <= {hiByte_q, bus.din};
        end
        if (rdIssue) begin
            preData_q <= mem[rdPtr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            preValid_q <= 1'b0;
            preLast_q  <= 1'b0;
        end else if (rdIssue) begin
            preValid_q <= 1'b1;
            preLast_q  <= (rdAddr_q == LAST_ADDR);
        end else if (outLoad) begin
            preValid_q <= 1'b0;
            preLast_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outLast_q  <= 1'b0;
        end else if (outLoad) begin
            outValid_q <= 1'b1;
            outData_q  <= preData_q;
            outLast_q  <= preLast_q;
        end else if (outAccept) begin
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
        end
    end

    assign bus.pix_data   = outData_q;
    assign bus.pix_valid  = outValid_q;
    assign bus.pix_last   = outLast_q;
    assign bus.line_drop  = lineDrop_q;
    assign bus.short_line = shortLine_q;

endmodule

// File: doc/ov7670_line_buffer.md
# ov7670_line_buffer

Ping-pong line buffer directly downstream of the OV7670 capture stage. It packs the capture byte stream (`dout`/`hsync`/`vde`) into 16-bit RGB565 pixels and stores each line in one of two banks. It then replays completed lines to the next pipeline stage over a valid/ready stream. Lines that cannot be stored are dropped whole and flagged; a partial line is never emitted.

## Interface
- `LINE_PIXELS`, 640: pixels per line (bytes per line = 2*LINE_PIXELS).
- `ADDR_WIDTH`, 10: bank address width; must satisfy 2^ADDR_WIDTH >= LINE_PIXELS.

Ports:
- `clk` in 1: core clock, same domain as the capture outputs.
- `reset` in 1: synchronous, active-high.
- `din` in 8: capture byte.
- `hsync` in 1: one-cycle line-start pulse; precedes the first `vde` of each line.
- `vde` in 1: `din` valid.
- `pix_data` out 16: RGB565 pixel.
- `pix_valid` out 1: `pix_data` valid.
- `pix_ready` in 1: downstream accepts the pixel.
- `pix_last` out 1: qualifies the last pixel of a line.
- `line_drop` out 1: one-cycle pulse; line discarded because no bank was free.
- `short_line` out 1: one-cycle pulse; line ended before LINE_PIXELS pixels were written.

## Operation
- Storage is two banks of LINE_PIXELS x 16, built as a single synchronous-read RAM of 2*LINE_PIXELS words. Control state is `wr_bank`, `rd_bank`, `bank_full[1:0]`, `wr_en`, byte phase, `wr_addr`, `rd_addr`.
- Reset behaviour:
  - All flags and pointers are cleared and `wr_en`=0. Bytes are ignored until the first `hsync`.
  - All outputs are 0.
- On `hsync`:
  - Byte phase and `wr_addr` are cleared.
  - If the previous line was open (`wr_en`=1, not committed), `short_line` pulses and that bank is not committed.
  - If `bank_full[wr_bank]`=1, `line_drop` pulses and `wr_en`=0 until the next `hsync`. Otherwise `wr_en`=1.
  - A `vde` byte in the same cycle as `hsync` is ignored.
- Packing, when `vde`=1 and `wr_en`=1:
  - An even byte is latched into `pix_data[15:8]` position.
  - An odd byte completes the pixel, which is written at `{wr_bank, wr_addr}`, then `wr_addr` increments.
- Commit:
  - The write of pixel LINE_PIXELS-1 sets `bank_full[wr_bank]`, toggles `wr_bank` and clears `wr_en`.
  - Bytes after commit and before the next `hsync` are ignored.
  - A dangling odd byte at `hsync` is discarded silently.
- Read:
  - While `bank_full[rd_bank]`=1, pixels 0..LINE_PIXELS-1 are presented in order.
  - `pix_last`=1 with pixel LINE_PIXELS-1.
  - When the last pixel is accepted (`pix_valid`&`pix_ready`), `bank_full[rd_bank]` is cleared, `rd_bank` toggles and `rd_addr` returns to 0.
- Simultaneous events:
  - A commit on one bank and a free on the other in the same cycle are both honoured.
  - A free and an `hsync` test in the same cycle: the `hsync` test sees the pre-free value, so the line is dropped.

## Timing
- `pix_valid` rises 2 cycles after the clock edge that writes the last pixel of a line.
- Once `pix_valid`=1, `pix_data` and `pix_last` hold stable until accepted.
- `pix_valid` is not withdrawn without acceptance.
- With `pix_ready` held at 1, the block delivers 1 pixel/cycle with no bubbles within a line. There are at most 2 idle cycles between back-to-back stored lines.
- RAM read latency is 1 cycle. A prefetch/skid register provides full throughput under arbitrary `pix_ready`.
- `line_drop` and `short_line` are registered and appear 1 cycle after the `hsync` edge.
- Reset mid-readout: `pix_valid`=0 the cycle after reset. No stale pixels emerge afterwards.
- `LINE_PIXELS` arithmetic: `wr_addr`/`rd_addr` compare against LINE_PIXELS-1 and never wrap within a bank.

## Test plan
1. LINE_PIXELS=8, `pix_ready`=1: `hsync`, then bytes 0x00..0x0F → pixels 0x0001, 0x0203, ..., 0x0E0F. `pix_last` is set on 0x0E0F only. `pix_valid` rises 2 cycles after byte 0x0F.
2. Backpressure: same line with `pix_ready` toggling 1,0,0,1,... → each pixel is held until accepted, the sequence is unchanged, and exactly 8 beats occur.
3. Overflow: `pix_ready`=0 and three full lines (A, B, C) → `line_drop` pulses once, 1 cycle after C's `hsync`. Releasing `pix_ready` yields 16 beats, A then B, with `pix_last` on beats 8 and 16.
4. Short line: `hsync`, 5 bytes, `hsync`, full line D → `short_line` pulses once. Only D's 8 pixels are output.
5. Overlong line: 20 bytes after `hsync` → only the first 8 pixels are output. Bytes 17-20 are ignored and no flag is raised.
6. Reset during readout of pixel 3 → `pix_valid`=0 next cycle. Bytes arriving before the next `hsync` produce no output, and the next full line outputs normally.
